// File: rtl/ps2_rx_if.sv
// rtl/ps2_rx_if.sv - scan-code event bus from the PS/2 receiver to the key-matrix stage
interface ps2_rx_if;
  logic [7:0] code;
  logic       ext;
  logic       rls;
  logic       code_vld;
  logic       err;

  modport master (
    output code,
    output ext,
    output rls,
    output code_vld,
    output err
  );

  modport slave (
    input code,
    input ext,
    input rls,
    input code_vld,
    input err
  );
endinterface

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host receiver: sync, glitch filter, deframe, E0/F0 folding
module ps2_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     ps2clk,
  input  logic     ps2dat,
  ps2_rx_if.master rx
);

  localparam logic [7:0]  FILT_LAST = 8'(FILTER_LEN - 1);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // synchroniser flops, idle-high like the bus itself
  logic       clk_s1, clk_s2, dat_s1, dat_s2;
  // filtered lines and their run-length counters
  logic       clk_f, dat_f, clk_f_q;
  logic [7:0] clk_cnt, dat_cnt;
  logic       fall;

  state_t     state_q, state_d;
  logic [2:0] bitcnt_q;
  logic [7:0] shreg_q;
  logic       par_q;
  logic [15:0] tocnt_q;
  logic       ext_pend_q, rls_pend_q;

  logic       frame_good, frame_bad, timeout;
  logic       par_ok;
  logic       is_prefix;

  logic [7:0] code_q;
  logic       ext_q, rls_q, code_vld_q, err_q;

  // two-flop synchronisers for both asynchronous pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2dat;
      dat_s2 <= dat_s1;
    end
  end

  // ps2clk filter: toggle only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_f   <= 1'b1;
      clk_cnt <= 8'd0;
    end else if (clk_s2 == clk_f) begin
      clk_cnt <= 8'd0;
    end else if (clk_cnt == FILT_LAST) begin
      clk_f   <= ~clk_f;
      clk_cnt <= 8'd0;
    end else begin
      clk_cnt <= clk_cnt + 8'd1;
    end
  end

  // ps2dat filter: same rule, so both lines see identical latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_f   <= 1'b1;
      dat_cnt <= 8'd0;
    end else if (dat_s2 == dat_f) begin
      dat_cnt <= 8'd0;
    end else if (dat_cnt == FILT_LAST) begin
      dat_f   <= ~dat_f;
      dat_cnt <= 8'd0;
    end else begin
      dat_cnt <= dat_cnt + 8'd1;
    end
  end

  // registered copy of filtered ps2clk for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_f_q <= 1'b1;
    end else begin
      clk_f_q <= clk_f;
    end
  end

  assign fall      = clk_f_q & ~clk_f;
  // odd parity over the data byte and the parity bit
  assign par_ok    = ^{shreg_q, par_q};
  assign is_prefix = (shreg_q == 8'hE0) || (shreg_q == 8'hF0);

  // frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state and frame verdict; timeout wins only when no fall arrives that cycle
  always_comb begin
    state_d    = state_q;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    timeout    = 1'b0;
    if ((state_q != IDLE) && !fall && (tocnt_q == TO_LAST)) begin
      timeout = 1'b1;
      state_d = IDLE;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (!dat_f) state_d = DATA;
        end
        DATA: begin
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (dat_f && par_ok) frame_good = 1'b1;
          else frame_bad = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // bit counter, shift register, parity latch and inter-fall timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt_q <= 3'd0;
      shreg_q  <= 8'd0;
      par_q    <= 1'b0;
      tocnt_q  <= 16'd0;
    end else begin
      if (state_q == IDLE || fall || timeout) tocnt_q <= 16'd0;
      else tocnt_q <= tocnt_q + 16'd1;

      if (fall) begin
        case (state_q)
          IDLE: begin
            if (!dat_f) begin
              bitcnt_q <= 3'd0;
              shreg_q  <= 8'd0;
            end
          end
          DATA: begin
            shreg_q[bitcnt_q] <= dat_f;
            bitcnt_q          <= bitcnt_q + 3'd1;
          end
          PARITY: par_q <= dat_f;
          default: ;
        endcase
      end
    end
  end

  // prefix folding and the single-cycle code/err strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_pend_q <= 1'b0;
      rls_pend_q <= 1'b0;
      code_q     <= 8'd0;
      ext_q      <= 1'b0;
      rls_q      <= 1'b0;
      code_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      code_vld_q <= 1'b0;
      err_q      <= frame_bad | timeout;
      if (frame_bad || timeout) begin
        ext_pend_q <= 1'b0;
        rls_pend_q <= 1'b0;
      end else if (frame_good) begin
        if (shreg_q == 8'hE0) begin
          ext_pend_q <= 1'b1;
        end else if (shreg_q == 8'hF0) begin
          rls_pend_q <= 1'b1;
        end else if (!is_prefix) begin
          code_q     <= shreg_q;
          ext_q      <= ext_pend_q;
          rls_q      <= rls_pend_q;
          code_vld_q <= 1'b1;
          ext_pend_q <= 1'b0;
          rls_pend_q <= 1'b0;
        end
      end
    end
  end

  assign rx.code     = code_q;
  assign rx.ext      = ext_q;
  assign rx.rls      = rls_q;
  assign rx.code_vld = code_vld_q;
  assign rx.err      = err_q;

endmodule
